// File: rtl/spike_encoder_pkg.sv
// Shared constants and types for the spike encoder, ffi and column logic.
package spike_encoder_pkg;

    // Default lane count and spike-time width
    localparam int DEF_NUM_SPIKES = 16;
    localparam int DEF_TIME_W     = 3;

    // One gamma cycle is 2^TIME_W clock steps
    localparam int GAMMA_LEN = 1 << DEF_TIME_W;

    // All-ones time marks a lane that does not spike in this gamma cycle
    localparam logic [DEF_TIME_W-1:0] NO_SPIKE = '1;

    // Encoder sequencing
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/spike_encoder_lane.sv
// One spike lane: holds the scheduled time and decodes the active-low line.
module spike_lane
    import spike_encoder_pkg::*;
#(
    parameter int TIME_W = DEF_TIME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,      // accept edge: capture time_in
    input  logic              clear,     // gamma cycle ended with no reload
    input  logic              run,       // encoder is inside a gamma cycle
    input  logic [TIME_W-1:0] time_in,
    input  logic [TIME_W-1:0] step,
    output logic              spike_l
);

    // All-ones at this lane's width is the "never spikes" code
    localparam logic [TIME_W-1:0] NO_SPK = {TIME_W{1'b1}};

    logic [TIME_W-1:0] t_q;

    // Time register: reload on accept, forget it once the gamma cycle is over
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= NO_SPK;
        end else if (load) begin
            t_q <= time_in;
        end else if (clear) begin
            t_q <= NO_SPK;
        end
    end

    // Line falls at its step and stays low to the end of the gamma cycle,
    // since step only counts up within a cycle; registers only feed this.
    always_comb begin
        spike_l = !(run && (t_q != NO_SPK) && (step >= t_q));
    end

endmodule

// File: rtl/spike_encoder.sv
// Race-logic spike encoder: replays one vector of spike times over a gamma
// cycle of 2^TIME_W steps as active-low spike lines toward the ffi stage.
module spike_encoder
    import spike_encoder_pkg::*;
#(
    parameter int NUM_SPIKES = DEF_NUM_SPIKES,
    parameter int TIME_W     = DEF_TIME_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_SPIKES*TIME_W-1:0] in_times,
    output logic [NUM_SPIKES-1:0]        should_spike_out_l,
    output logic                         spikes_valid,
    output logic [TIME_W-1:0]            time_step,
    output logic                         gamma_start,
    output logic                         gamma_end
);

    // Last step of the gamma cycle (GAMMA_LEN-1) is all ones at TIME_W bits
    localparam logic [TIME_W-1:0] LAST_STEP = {TIME_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic [TIME_W-1:0] step_q;
    logic              last_step;
    logic              accept;
    logic              clear_times;
    logic              run;

    // Handshake terms depend only on rst and registered state, never in_valid
    always_comb begin
        last_step   = (state_q == RUN) && (step_q == LAST_STEP);
        in_ready    = !rst && ((state_q == IDLE) || last_step);
        accept      = in_valid && in_ready;
        clear_times = last_step && !accept;
    end

    // State register; reset aborts any running gamma cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an accept on the last step keeps RUN with no bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_step && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Step counter: restarts at 0 on accept, counts in RUN, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
        end else if (accept) begin
            step_q <= '0;
        end else if (state_q == RUN) begin
            step_q <= step_q + 1'b1;
        end else begin
            step_q <= '0;
        end
    end

    // Output decode from registered state and step
    always_comb begin
        run          = (state_q == RUN);
        spikes_valid = run;
        gamma_start  = run && (step_q == '0);
        gamma_end    = last_step;
        time_step    = step_q;
    end

    // One lane per spike line, each with its own slice of in_times
    for (genvar i = 0; i < NUM_SPIKES; i++) begin : g_lane
        spike_lane #(
            .TIME_W (TIME_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (accept),
            .clear   (clear_times),
            .run     (run),
            .time_in (in_times[i*TIME_W +: TIME_W]),
            .step    (step_q),
            .spike_l (should_spike_out_l[i])
        );
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder with 4 lanes and 3-bit spike times.
module tb_spike_encoder;

    localparam int N  = 4;
    localparam int TW = 3;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*TW-1:0] in_times;
    logic [N-1:0]    out_l;
    logic            spikes_valid;
    logic [TW-1:0]   time_step;
    logic            gamma_start;
    logic            gamma_end;

    int checks = 0;
    int errors = 0;

    spike_encoder #(.NUM_SPIKES(N), .TIME_W(TW)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_times           (in_times),
        .should_spike_out_l (out_l),
        .spikes_valid       (spikes_valid),
        .time_step          (time_step),
        .gamma_start        (gamma_start),
        .gamma_end          (gamma_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full check of one RUN step with hand-computed output vector
    task automatic step_check(input int s, input logic [N-1:0] exp_l);
        chk($sformatf("out_l@%0d", s), 32'(out_l), 32'(exp_l));
        chk($sformatf("step@%0d", s), 32'(time_step), 32'(s));
        chk($sformatf("valid@%0d", s), 32'(spikes_valid), 32'd1);
        chk($sformatf("gstart@%0d", s), 32'(gamma_start), 32'(s == 0));
        chk($sformatf("gend@%0d", s), 32'(gamma_end), 32'(s == 7));
        chk($sformatf("ready@%0d", s), 32'(in_ready), 32'(s == 7));
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_out"}, 32'(out_l), 32'hF);
        chk({tag, "_valid"}, 32'(spikes_valid), 32'd0);
        chk({tag, "_step"}, 32'(time_step), 32'd0);
        chk({tag, "_gend"}, 32'(gamma_end), 32'd0);
        chk({tag, "_gstart"}, 32'(gamma_start), 32'd0);
    endtask

    // Expected vectors per step, index = step
    logic [N-1:0] exp_a [8];
    logic [N-1:0] exp_b [8];

    initial begin
        // times {3:7,2:5,1:2,0:0}
        exp_a = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000};
        // times {3:6,2:6,1:7,0:1}
        exp_b = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b0010, 4'b0010};

        rst = 1'b1; in_valid = 1'b0; in_times = '0;
        tick(); tick();
        chk("ready_in_rst", 32'(in_ready), 32'd0);
        idle_check("rst_hold");

        // Release: first cycle after release is idle and ready
        rst = 1'b0;
        tick();
        idle_check("post_rst");
        chk("ready_post_rst", 32'(in_ready), 32'd1);

        // Gamma A
        in_valid = 1'b1;
        in_times = {3'd7, 3'd5, 3'd2, 3'd0};
        tick();
        in_valid = 1'b0;
        in_times = '0;
        for (int s = 0; s < 8; s++) begin
            step_check(s, exp_a[s]);
            tick();
        end
        idle_check("a_end");

        // Back-to-back: {7,7,7,3} then all-zero vector offered on step 7
        in_valid = 1'b1;
        in_times = {3'd7, 3'd7, 3'd7, 3'd3};
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 8; s++) begin
            step_check(s, (s >= 3) ? 4'b1110 : 4'b1111);
            if (s == 7) begin
                in_valid = 1'b1;
                in_times = '0;
            end
            tick();
        end
        in_valid = 1'b0;
        in_times = {3'd1, 3'd1, 3'd1, 3'd1};
        for (int s = 0; s < 8; s++) begin
            step_check(s, 4'b0000);
            tick();
        end
        idle_check("b2b_end");

        // Reset at step 4 aborts with no gamma_end
        in_valid = 1'b1;
        in_times = {3'd7, 3'd5, 3'd2, 3'd0};
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step_check(s, exp_a[s]);
            if (s < 4) tick();
        end
        rst = 1'b1;
        tick();
        idle_check("abort");
        chk("abort_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            idle_check($sformatf("abort_quiet%0d", k));
        end
        in_valid = 1'b1;
        in_times = {3'd0, 3'd0, 3'd0, 3'd7};
        tick();
        in_valid = 1'b0;
        step_check(0, 4'b0001);

        // Let that gamma finish
        for (int s = 0; s < 8; s++) tick();
        idle_check("restart_end");

        // Simultaneous rst and in_valid: nothing accepted
        rst = 1'b1;
        in_valid = 1'b1;
        in_times = '0;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        idle_check("rst_vs_valid");

        // Boundary times {6,6,7,1} with in_valid held and in_times churning
        in_valid = 1'b1;
        in_times = {3'd6, 3'd6, 3'd7, 3'd1};
        tick();
        for (int s = 0; s < 8; s++) begin
            step_check(s, exp_b[s]);
            in_times = (s[0]) ? '0 : {3'd2, 3'd3, 3'd0, 3'd4};
            if (s == 6) in_valid = 1'b0;
            tick();
        end
        idle_check("bound_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
